// File: rtl/pwr_pulse_gen.sv
// Pulsed-supply generator: bursts of PwrClk pulses with programmable on/off widths.
// Optional PWRCLK_STATS_EN adds a rising-edge pulse counter and a sticky abort flag.
module pwr_pulse_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] on_cycles,
    input  logic [CNT_W-1:0] off_cycles,
    input  logic [CNT_W-1:0] burst_len,
    output logic             PwrClk,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_idx
`ifdef PWRCLK_STATS_EN
    ,
    output logic [31:0]      total_pulses,
    output logic             abort_seen
`endif
);

    // state  | meaning
    // IDLE   | PwrClk low, waiting for en && start
    // ON     | PwrClk high, down-counting on_len
    // OFF    | PwrClk low guard gap, down-counting off_len
    // DONE   | one-cycle done strobe, busy still high
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] on_len_q, on_len_d;
    logic [CNT_W-1:0] off_len_q, off_len_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] idx_inc;
    logic             pwr_q, pwr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_acc;
    logic             abort_evt;

    function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    assign idx_inc = idx_q + ONE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        on_len_d  = on_len_q;
        off_len_d = off_len_q;
        burst_d   = burst_q;
        idx_d     = idx_q;
        pwr_d     = pwr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        start_acc = 1'b0;
        abort_evt = 1'b0;
        case (state_q)
            S_IDLE: begin
                pwr_d  = 1'b0;
                busy_d = 1'b0;
                if (en && start) begin
                    start_acc = 1'b1;
                    on_len_d  = nz(on_cycles);
                    off_len_d = nz(off_cycles);
                    burst_d   = nz(burst_len);
                    idx_d     = '0;
                    cnt_d     = nz(on_cycles) - ONE;
                    state_d   = S_ON;
                    pwr_d     = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_ON: begin
                if (!en) begin
                    abort_evt = 1'b1;
                end else if (cnt_q == '0) begin
                    idx_d = idx_inc;
                    pwr_d = 1'b0;
                    if (idx_inc == burst_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_OFF;
                        cnt_d   = off_len_q - ONE;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_OFF: begin
                if (!en) begin
                    abort_evt = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_ON;
                    cnt_d   = on_len_q - ONE;
                    pwr_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_DONE: begin
                abort_evt = !en;
                state_d   = S_IDLE;
                pwr_d     = 1'b0;
                busy_d    = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                pwr_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
        // en low wins over any completion decided above; pulse_idx keeps its value
        if (abort_evt) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = idx_q;
            pwr_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            on_len_q  <= '0;
            off_len_q <= '0;
            burst_q   <= '0;
            idx_q     <= '0;
            pwr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            on_len_q  <= on_len_d;
            off_len_q <= off_len_d;
            burst_q   <= burst_d;
            idx_q     <= idx_d;
            pwr_q     <= pwr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign PwrClk    = pwr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_idx = idx_q;

`ifdef PWRCLK_STATS_EN
    logic [31:0] total_q;
    logic        abort_q;

    // Count is bumped on the same edge that raises PwrClk, so it tracks the visible pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            total_q <= '0;
            abort_q <= 1'b0;
        end else begin
            if (pwr_d && !pwr_q)
                total_q <= total_q + 32'd1;
            if (abort_evt)
                abort_q <= 1'b1;
            else if (start_acc)
                abort_q <= 1'b0;
        end
    end

    assign total_pulses = total_q;
    assign abort_seen   = abort_q;
`endif

endmodule

// File: tb/tb_pwr_pulse_gen.sv
// Directed + randomized bench for pwr_pulse_gen against a closed-form burst waveform model.
// Stats ports are checked when PWRCLK_STATS_EN is defined.
module tb_pwr_pulse_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic [7:0] on_cycles = '0;
    logic [7:0] off_cycles = '0;
    logic [7:0] burst_len = '0;
    logic       PwrClk;
    logic       busy;
    logic       done;
    logic [7:0] pulse_idx;
`ifdef PWRCLK_STATS_EN
    logic [31:0] total_pulses;
    logic        abort_seen;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pwr_pulse_gen #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .on_cycles(on_cycles), .off_cycles(off_cycles), .burst_len(burst_len),
        .PwrClk(PwrClk), .busy(busy), .done(done), .pulse_idx(pulse_idx)
`ifdef PWRCLK_STATS_EN
        , .total_pulses(total_pulses), .abort_seen(abort_seen)
`endif
    );

    // Reference model: burst position k since the first ON cycle, plus latched lengths.
    bit          m_active = 0;
    int          m_k = 0;
    int          m_on = 1, m_off = 1, m_b = 1;
    int          m_hold = 0;
    logic [31:0] m_total = '0;
    bit          m_abort = 0;
    bit          chk_on = 0;

    function automatic int burst_span();
        return m_b * m_on + (m_b - 1) * m_off;
    endfunction

    function automatic void exp_out(output bit p, output bit b, output bit d, output int idx);
        int per, ph;
        if (!m_active) begin
            p = 0; b = 0; d = 0; idx = m_hold;
        end else if (m_k < burst_span()) begin
            per = m_on + m_off;
            ph  = m_k % per;
            p   = (ph < m_on);
            b   = 1; d = 0;
            idx = m_k / per + ((ph >= m_on) ? 1 : 0);
        end else begin
            p = 0; b = 1; d = 1; idx = m_b;
        end
    endfunction

    task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: check current outputs, drive inputs for the next edge, advance the model.
    task automatic cyc(input bit r, input bit e, input bit s, input int on, input int off, input int b);
        bit p, bz, d, np, nb, nd;
        int idx, nidx;
        @(negedge clk);
        exp_out(p, bz, d, idx);
        if (chk_on) begin
            chk1("PwrClk", {31'b0, PwrClk}, {31'b0, p});
            chk1("busy", {31'b0, busy}, {31'b0, bz});
            chk1("done", {31'b0, done}, {31'b0, d});
            chk1("pulse_idx", {24'b0, pulse_idx}, 32'(idx));
`ifdef PWRCLK_STATS_EN
            chk1("total_pulses", total_pulses, m_total);
            chk1("abort_seen", {31'b0, abort_seen}, {31'b0, m_abort});
`endif
        end
        rst = r; en = e; start = s;
        on_cycles = 8'(on); off_cycles = 8'(off); burst_len = 8'(b);
        if (r) begin
            m_active = 0; m_hold = 0; m_total = '0; m_abort = 0;
        end else if (!m_active) begin
            if (e && s) begin
                m_active = 1; m_k = 0; m_hold = 0; m_abort = 0;
                m_on  = (on == 0) ? 1 : on;
                m_off = (off == 0) ? 1 : off;
                m_b   = (b == 0) ? 1 : b;
            end
        end else if (!e) begin
            m_active = 0; m_hold = idx; m_abort = 1;
        end else if (m_k == burst_span()) begin
            m_active = 0; m_hold = m_b;
        end else begin
            m_k++;
        end
        if (!r) begin
            exp_out(np, nb, nd, nidx);
            if (np && !p) m_total = m_total + 32'd1;
        end
        chk_on = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(5);

        // 3/2/4 burst, then extra cycles past done
        cyc(0, 1, 1, 3, 2, 4);
        idle(22);

        // zero lengths become 1; then long pulses
        cyc(0, 1, 1, 0, 0, 0);
        idle(4);
        cyc(0, 1, 1, 255, 1, 2);
        idle(515);

        // abort on the 2nd cycle of pulse 3 (k = 17)
        cyc(0, 1, 1, 4, 4, 5);
        for (int i = 0; i < 17; i++) cyc(0, 1, 0, 4, 4, 5);
        cyc(0, 0, 0, 4, 4, 5);
        @(posedge clk); #1;
        chk1("abort_pwr", {31'b0, PwrClk}, 32'd0);
        chk1("abort_busy", {31'b0, busy}, 32'd0);
        chk1("abort_idx", {24'b0, pulse_idx}, 32'd2);
`ifdef PWRCLK_STATS_EN
        chk1("abort_total", total_pulses, 32'd5 * 32'd0 + 32'd3 + m_total - 32'd3);
        chk1("abort_flag", {31'b0, abort_seen}, 32'd1);
`endif
        idle(3);
        // start with en low is ignored
        cyc(0, 0, 1, 2, 2, 2);
        idle(3);

        // start held high with changing config: no restart mid-burst, ignored in DONE, taken in IDLE
        cyc(0, 1, 1, 2, 1, 2);
        for (int i = 0; i < 16; i++)
            cyc(0, 1, 1, $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
        idle(40);

        // reset in the middle of an ON phase
        cyc(0, 1, 1, 5, 5, 3);
        cyc(0, 1, 0, 5, 5, 3);
        cyc(0, 1, 0, 5, 5, 3);
        cyc(1, 1, 0, 5, 5, 3);
        @(posedge clk); #1;
        chk1("rst_pwr", {31'b0, PwrClk}, 32'd0);
        chk1("rst_busy", {31'b0, busy}, 32'd0);
        chk1("rst_idx", {24'b0, pulse_idx}, 32'd0);
`ifdef PWRCLK_STATS_EN
        chk1("rst_total", total_pulses, 32'd0);
`endif
        idle(3);

        // randomized bursts with occasional aborts, stray starts and resets
        for (int n = 0; n < 40; n++) begin
            cyc(0, 1, 1, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 5));
            for (int i = 0; i < 200 && m_active; i++)
                cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 40) != 0),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255));
            cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), 1, 1, 1);
            idle($urandom_range(0, 3));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
